mips_mem_responder: RTL and testbench

Single-port word-addressed memory responder serving the load/store and fetch side of the MIPS32 pipeline. It accepts requests over a valid/ready channel, commits writes immediately and returns read data in request order over a second valid/ready channel after a fixed pipeline latency. A credit counter keeps the response buffer from overflowing, so back-pressure on the response side never drops data.

---
 rtl/mips_mem_pkg.sv | 18 +
 rtl/resp_fifo.sv | 67 ++++++
 rtl/mips_mem_responder.sv | 111 +++++++++++
 tb/tb_mips_mem_responder.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared types and defaults for the MIPS memory responder; no logic, no latency.
// Holds the request-kind encoding and the pipe/FIFO sizing legality check.
package mips_mem_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 32;

    typedef enum logic {
        REQ_RD = 1'b0,
        REQ_WR = 1'b1
    } req_kind_e;

    // The FIFO must absorb every read still in the pipe when the consumer stalls.
    function automatic bit cfg_legal(input int latency, input int fifo_depth);
        return (latency >= 1) && (latency <= 4) && (fifo_depth >= latency + 1);
    endfunction

endpackage

// File: rtl/resp_fifo.sv
// Generic synchronous FIFO; push visible at head one edge later, head is combinational.
// Pushes into a full FIFO are taken only when a pop happens in the same cycle.
module resp_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wr_dat_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rd_dat_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full_o   = (cnt_q == CNT_W'(DEPTH));
    assign empty_o  = (cnt_q == '0);
    assign count_o  = cnt_q;
    assign rd_dat_o = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) wr_ptr_d = next_ptr(wr_ptr_q);
        if (do_pop)  rd_ptr_d = next_ptr(rd_ptr_q);
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_dat_i;
    end

endmodule

// File: rtl/mips_mem_responder.sv
// Word-addressed memory: writes commit on accept, reads reach the response FIFO LATENCY edges later.
// Credits (pipe + FIFO occupancy) drop req_ready for all requests once FIFO_DEPTH reads are outstanding.
module mips_mem_responder
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int LATENCY    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata
);

    localparam int               CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    if (!cfg_legal(LATENCY, FIFO_DEPTH)) begin : g_cfg_err
        $error("mips_mem_responder: LATENCY must be 1..4 and FIFO_DEPTH >= LATENCY+1");
    end

    logic [DATA_W-1:0]  mem_q [2**ADDR_W];
    logic               out_of_reset_q;
    logic [CNT_W-1:0]   in_flight_q, in_flight_d;
    logic [LATENCY-1:0] pipe_vld_q, pipe_vld_d;
    logic [DATA_W-1:0]  pipe_dat_q [LATENCY];
    logic [CNT_W-1:0]   pipe_cnt;

    req_kind_e          req_kind;
    logic               req_acc, rd_acc, wr_acc, rsp_pop;
    logic               fifo_full, fifo_empty;
    logic [CNT_W-1:0]   fifo_cnt;

    assign req_kind  = req_kind_e'(req_we);
    assign req_ready = out_of_reset_q && (in_flight_q < DEPTH_C);
    assign req_acc   = req_valid && req_ready;
    assign rd_acc    = req_acc && (req_kind == REQ_RD);
    assign wr_acc    = req_acc && (req_kind == REQ_WR);
    assign rsp_valid = !fifo_empty;
    assign rsp_pop   = rsp_valid && rsp_ready;

    always_comb begin
        pipe_vld_d    = '0;
        pipe_vld_d[0] = rd_acc;
        for (int i = 1; i < LATENCY; i++) pipe_vld_d[i] = pipe_vld_q[i-1];
    end

    always_comb begin
        in_flight_d = in_flight_q;
        case ({rd_acc, rsp_pop})
            2'b10:   in_flight_d = in_flight_q + CNT_W'(1);
            2'b01:   in_flight_d = in_flight_q - CNT_W'(1);
            default: in_flight_d = in_flight_q;
        endcase
    end

    always_comb begin
        pipe_cnt = '0;
        for (int i = 0; i < LATENCY; i++) pipe_cnt = pipe_cnt + CNT_W'(pipe_vld_q[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_of_reset_q <= 1'b0;
            in_flight_q    <= '0;
            pipe_vld_q     <= '0;
        end else begin
            out_of_reset_q <= 1'b1;
            in_flight_q    <= in_flight_d;
            pipe_vld_q     <= pipe_vld_d;
        end
    end

    // Memory and pipe data carry no reset; the pipe valid bits qualify them.
    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[req_addr] <= req_wdata;
        if (rd_acc) pipe_dat_q[0] <= mem_q[req_addr];
        for (int i = 1; i < LATENCY; i++) pipe_dat_q[i] <= pipe_dat_q[i-1];
    end

    resp_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_resp_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_i   (pipe_vld_q[LATENCY-1]),
        .wr_dat_i (pipe_dat_q[LATENCY-1]),
        .pop_i    (rsp_pop),
        .rd_dat_o (rsp_rdata),
        .full_o   (fifo_full),
        .empty_o  (fifo_empty),
        .count_o  (fifo_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(pipe_vld_q[LATENCY-1] && fifo_full && !rsp_pop));
            assert (in_flight_q == pipe_cnt + fifo_cnt);
        end
    end

endmodule

// File: tb/tb_mips_mem_responder.sv
// Scoreboarded bench for mips_mem_responder: model memory predicts read data at acceptance,
// responses are popped from the expected queue and compared when the DUT hands them out.
module tb_mips_mem_responder;

    localparam int ADDR_W     = 10;
    localparam int DATA_W     = 32;
    localparam int LATENCY    = 2;
    localparam int FIFO_DEPTH = 4;

    logic              clk;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;

    mips_mem_responder #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .LATENCY    (LATENCY),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_mis = 0;
    int          cyc_n = 0;
    int          n_acc = 0;
    bit          lat_chk = 0;
    bit          rdy_chk = 0;
    logic [31:0] mdl_mem [1024];
    logic [31:0] exp_q [$];
    int          acc_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc_n);
        end
    endtask

    // One clock cycle: drive at the negedge, resolve handshakes before the posedge.
    task automatic cyc(input logic v, input logic we, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d, input logic rr);
        bit acc;
        int t;
        req_valid = v;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        rsp_ready = rr;
        #1;
        acc = v && req_ready;
        if (rsp_valid) begin
            if (exp_q.size() == 0) begin
                check("stale_rsp", {31'b0, rsp_valid}, 32'd0);
            end else if (!rr) begin
                check("hold", rsp_rdata, exp_q[0]);
            end else begin
                check("rdata", rsp_rdata, exp_q.pop_front());
                t = acc_q.pop_front();
                if (lat_chk) check("latency", cyc_n - t, LATENCY + 1);
            end
        end
        if (v && rdy_chk) check("rdy_b2b", {31'b0, req_ready}, 32'd1);
        if (acc) begin
            n_acc++;
            if (we) mdl_mem[a] = d;
            else begin
                exp_q.push_back(mdl_mem[a]);
                acc_q.push_back(cyc_n);
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc_n++;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) cyc(1'b0, 1'b0, '0, '0, 1'b1);
        if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 32'd0);
        cyc(1'b0, 1'b0, '0, '0, 1'b1);
    endtask

    task automatic release_reset();
        rst_n = 1'b1;
        #1;
        check("rdy_before_edge", {31'b0, req_ready}, 32'd0);
        @(posedge clk);
        #1;
        check("rdy_after_edge", {31'b0, req_ready}, 32'd1);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        rst_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_rdy", {31'b0, req_ready}, 32'd0);
        check("rst_vld", {31'b0, rsp_valid}, 32'd0);
        release_reset();

        // Write then read the same word on the next cycle.
        lat_chk = 1;
        cyc(1'b1, 1'b1, 10'd5, 32'hDEADBEEF, 1'b1);
        cyc(1'b1, 1'b0, 10'd5, '0, 1'b1);
        drain();

        // Back-to-back: writes 0..7, reads 7..0 with req_ready required high throughout.
        rdy_chk = 1;
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 10'(i), 32'h100 + 32'(i), 1'b1);
        for (int i = 7; i >= 0; i--) cyc(1'b1, 1'b0, 10'(i), '0, 1'b1);
        rdy_chk = 0;
        drain();
        lat_chk = 0;

        // Back-pressure: only FIFO_DEPTH reads get in, and a write then stalls too.
        n0 = n_acc;
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 10'(i), '0, 1'b0);
        check("bp_accepts", n_acc - n0, FIFO_DEPTH);
        check("bp_wr_stall", {31'b0, req_ready}, 32'd0);
        n0 = n_acc;
        cyc(1'b1, 1'b1, 10'd100, 32'h12345678, 1'b0);
        check("bp_wr_not_taken", n_acc - n0, 32'd0);
        drain();

        // Simultaneous accept and pop with three reads outstanding.
        for (int i = 1; i <= 3; i++) cyc(1'b1, 1'b0, 10'(i), '0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, '0, '0, 1'b0);
        check("sim_pre_inflight", {29'b0, dut.in_flight_q}, 32'd3);
        cyc(1'b1, 1'b0, 10'd4, '0, 1'b1);
        check("sim_inflight", {29'b0, dut.in_flight_q}, 32'd3);
        check("sim_rdy", {31'b0, req_ready}, 32'd1);
        cyc(1'b1, 1'b0, 10'd6, '0, 1'b0);
        cyc(1'b0, 1'b0, '0, '0, 1'b0);
        check("sim_full_rdy", {31'b0, req_ready}, 32'd0);
        drain();

        // Boundary addresses must not alias.
        lat_chk = 1;
        cyc(1'b1, 1'b1, 10'd1023, 32'hA5A5A5A5, 1'b1);
        cyc(1'b1, 1'b1, 10'd0, 32'h5A5A5A5A, 1'b1);
        cyc(1'b1, 1'b0, 10'd1023, '0, 1'b1);
        cyc(1'b1, 1'b0, 10'd0, '0, 1'b1);
        drain();
        lat_chk = 0;

        // Reset with three reads outstanding: nothing stale may come out afterwards.
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 10'(i), '0, 1'b0);
        rst_n = 1'b0;
        req_valid = 1'b0;
        #1;
        check("midrst_vld", {31'b0, rsp_valid}, 32'd0);
        check("midrst_rdy", {31'b0, req_ready}, 32'd0);
        check("midrst_inflight", {29'b0, dut.in_flight_q}, 32'd0);
        exp_q.delete();
        acc_q.delete();
        @(negedge clk);
        @(negedge clk);
        release_reset();
        for (int i = 0; i < 6; i++) begin
            check("no_stale", {31'b0, rsp_valid}, 32'd0);
            cyc(1'b0, 1'b0, '0, '0, 1'b1);
        end
        // Memory survives reset.
        lat_chk = 1;
        cyc(1'b1, 1'b0, 10'd1023, '0, 1'b1);
        cyc(1'b1, 1'b0, 10'd5, '0, 1'b1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
